// File: rtl/isqrt_arb_pkg.sv
// Shared widths and tag sizing for the isqrt round-robin arbiter.
// Tags identify the requester that owns an in-flight isqrt issue.
package isqrt_arb_pkg;
  localparam int ISQRT_IN_W  = 32;
  localparam int ISQRT_OUT_W = 16;
  localparam int N_REQ_DEF   = 4;
  localparam int TAG_W_DEF   = $clog2(N_REQ_DEF);

  typedef logic [TAG_W_DEF-1:0] tag_t;

  // A single requester still needs one tag bit so the vectors stay legal.
  function automatic int tag_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/isqrt_arbiter_if.sv
// Requester and isqrt-facing bus of the arbiter; slave = arbiter side,
// master = requesters plus the external isqrt unit.
interface isqrt_arbiter_if #(parameter int N_REQ = 4);
  import isqrt_arb_pkg::*;

  logic [N_REQ-1:0]                  req_vld;
  logic [N_REQ-1:0][ISQRT_IN_W-1:0]  req_x;
  logic [N_REQ-1:0]                  req_rdy;
  logic [N_REQ-1:0]                  rsp_vld;
  logic [ISQRT_OUT_W-1:0]            rsp_y;
  logic                              isqrt_x_vld;
  logic [ISQRT_IN_W-1:0]             isqrt_x;
  logic                              isqrt_y_vld;
  logic [ISQRT_OUT_W-1:0]            isqrt_y;

  modport slave (
    input  req_vld, req_x, isqrt_y_vld, isqrt_y,
    output req_rdy, rsp_vld, rsp_y, isqrt_x_vld, isqrt_x
  );

  modport master (
    output req_vld, req_x, isqrt_y_vld, isqrt_y,
    input  req_rdy, rsp_vld, rsp_y, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/isqrt_arb_tag_line.sv
// Valid+tag delay line, LATENCY stages, output LATENCY cycles after input.
// Never stalls: shifts every cycle, so it cannot apply backpressure.
module isqrt_arb_tag_line #(
  parameter int LATENCY = 16,
  parameter int TAG_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag,
  output logic             any_vld
);
  logic [LATENCY-1:0]            vld_q, vld_d;
  logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;

  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = in_vld;
    tag_d[0] = in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_tag = tag_q[LATENCY-1];
  assign any_vld = |vld_q;
endmodule

// File: rtl/isqrt_arbiter.sv
// Round-robin share of one pipelined isqrt among N_REQ requesters; LATENCY+2 cycles request to rsp_vld.
// Grants at most one request per cycle via req_rdy; results cannot be stalled. ISQRT_ARB_CHECK_EN builds err checker.
module isqrt_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 16
) (
  input  logic             clk,
  input  logic             rst,
  isqrt_arbiter_if.slave   bus,
  output logic             busy,
  output logic             err
);
  localparam int TAG_W = tag_w(N_REQ);

  logic [TAG_W-1:0]       ptr_q, ptr_d;
  logic [TAG_W-1:0]       iss_tag_q, iss_tag_d;
  logic                   isqrt_x_vld_q, isqrt_x_vld_d;
  logic [ISQRT_IN_W-1:0]  isqrt_x_q, isqrt_x_d;
  logic [N_REQ-1:0]       rsp_vld_q, rsp_vld_d;
  logic [ISQRT_OUT_W-1:0] rsp_y_q, rsp_y_d;
  logic [N_REQ-1:0]       gnt_oh;
  logic [TAG_W-1:0]       gnt_idx;
  logic                   gnt_vld;
  logic                   ret_vld;
  logic [TAG_W-1:0]       ret_tag;
  logic                   line_busy;

  function automatic logic [TAG_W-1:0] rr_idx(logic [TAG_W-1:0] p, int k);
    int s;
    s = int'(p) + k;
    return TAG_W'((s >= N_REQ) ? s - N_REQ : s);
  endfunction

  // First requester at or after ptr, wrapping around.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_vld && bus.req_vld[rr_idx(ptr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx(ptr_q, k);
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  assign bus.req_rdy = gnt_oh;

  always_comb begin
    ptr_d         = ptr_q;
    iss_tag_d     = iss_tag_q;
    isqrt_x_vld_d = gnt_vld;
    isqrt_x_d     = isqrt_x_q;
    if (gnt_vld) begin
      ptr_d     = (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      iss_tag_d = gnt_idx;
      isqrt_x_d = bus.req_x[gnt_idx];
    end
  end

  isqrt_arb_tag_line #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_tag_line (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (isqrt_x_vld_q),
    .in_tag  (iss_tag_q),
    .out_vld (ret_vld),
    .out_tag (ret_tag),
    .any_vld (line_busy)
  );

  // The tag line, not isqrt_y_vld, decides when a result is real.
  always_comb begin
    rsp_vld_d = '0;
    rsp_y_d   = rsp_y_q;
    if (ret_vld) begin
      rsp_vld_d[ret_tag] = 1'b1;
      rsp_y_d            = bus.isqrt_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q         <= '0;
      iss_tag_q     <= '0;
      isqrt_x_vld_q <= 1'b0;
      isqrt_x_q     <= '0;
      rsp_vld_q     <= '0;
      rsp_y_q       <= '0;
    end else begin
      ptr_q         <= ptr_d;
      iss_tag_q     <= iss_tag_d;
      isqrt_x_vld_q <= isqrt_x_vld_d;
      isqrt_x_q     <= isqrt_x_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_y_q       <= rsp_y_d;
    end
  end

  assign bus.isqrt_x_vld = isqrt_x_vld_q;
  assign bus.isqrt_x     = isqrt_x_q;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_y       = rsp_y_q;
  assign busy            = isqrt_x_vld_q | line_busy;

`ifdef ISQRT_ARB_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (bus.isqrt_y_vld != ret_vld);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_isqrt_y_vld;
  assign unused_isqrt_y_vld = bus.isqrt_y_vld;
  assign err                = 1'b0;
`endif
endmodule

// File: tb/tb_isqrt_arbiter.sv
// Randomized bench for isqrt_arbiter with a behavioural isqrt pipeline and a
// scoreboard of expected grants/responses derived from the round-robin rules.
module tb_isqrt_arbiter;
  import isqrt_arb_pkg::*;

  localparam int N = 4;
  localparam int L = 4;
`ifdef ISQRT_ARB_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct { int due; int r; logic [ISQRT_OUT_W-1:0] y; } exp_t;
  typedef struct { int r; logic [ISQRT_IN_W-1:0] x; } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;
  logic inj = 1'b0;

  always #5 clk = ~clk;

  isqrt_arbiter_if #(.N_REQ(N)) bus();

  isqrt_arbiter #(.N_REQ(N), .LATENCY(L)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  logic [N-1:0]            want = '0;
  logic [N-1:0]            cont = '0;
  logic [ISQRT_IN_W-1:0]   xv [N];
  bit                      rnd = 1'b0;
  exp_t                    q [$];
  pend_t                   pend [$];
  int                      ptr_m = 0;
  int                      last_g = -1;
  logic [ISQRT_IN_W-1:0]   last_x = '0;
  int                      waitc [N];
  int                      cyc = 0;
  logic                    err_exp = 1'b0;
  int                      n_chk = 0;
  int                      n_pass = 0;

  assign bus.req_vld = want;
  for (genvar i = 0; i < N; i++) begin : g_x
    assign bus.req_x[i] = xv[i];
  end

  // Behavioural isqrt unit: exact bitwise root, L-cycle pipeline, same reset.
  function automatic logic [ISQRT_OUT_W-1:0] isqrt_bits(logic [ISQRT_IN_W-1:0] x);
    logic [63:0] r = 0;
    logic [63:0] t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  logic [L-1:0]           mv;
  logic [ISQRT_OUT_W-1:0] my [L];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv <= '0;
    end else begin
      mv    <= {mv[L-2:0], bus.isqrt_x_vld};
      my[0] <= isqrt_bits(bus.isqrt_x);
      for (int i = 1; i < L; i++) my[i] <= my[i-1];
    end
  end

  assign bus.isqrt_y_vld = mv[L-1] | inj;
  assign bus.isqrt_y     = my[L-1];

  // Reference root from floating point, corrected to the exact floor.
  function automatic logic [ISQRT_OUT_W-1:0] ref_isqrt(logic [ISQRT_IN_W-1:0] x);
    longint v = longint'({32'd0, x});
    longint y = longint'($sqrt(real'(v)));
    while (y * y > v) y--;
    while ((y + 1) * (y + 1) <= v) y++;
    return ISQRT_OUT_W'(y);
  endfunction

  function automatic logic [ISQRT_IN_W-1:0] rand_x();
    logic [31:0] k = 32'($urandom_range(1, 65535));
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 300));
      2:       return k * k;
      default: return k * k - 1;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rsp;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && want[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_rdy", bus.req_rdy, exp_rdy);
    chk("isqrt_x_vld", bus.isqrt_x_vld, last_g >= 0);
    if (last_g >= 0) chk("isqrt_x", bus.isqrt_x, last_x);
    exp_rsp = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e = q.pop_front();
      exp_rsp[e.r] = 1'b1;
      chk("rsp_y", bus.rsp_y, e.y);
    end
    chk("rsp_vld", bus.rsp_vld, exp_rsp);
    chk("busy", busy, q.size() != 0);
    chk("err", err, err_exp);
    for (int i = 0; i < N; i++) begin
      if (want[i] && !bus.req_rdy[i]) begin
        waitc[i]++;
        chk("fair_wait", waitc[i] < N, 1);
      end else begin
        waitc[i] = 0;
      end
    end
    if (g >= 0) begin
      q.push_back('{due: cyc + L + 2, r: g, y: ref_isqrt(xv[g])});
      ptr_m  = (g + 1) % N;
      last_g = g;
      last_x = xv[g];
    end else begin
      last_g = -1;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (g >= 0 && !cont[g]) want[g] = 1'b0;
    if (pend.size() > 0 && !want[pend[0].r]) begin
      pend_t p = pend.pop_front();
      want[p.r] = 1'b1;
      xv[p.r]   = p.x;
    end
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!want[i] && $urandom_range(0, 2) == 0) begin
          want[i] = 1'b1;
          xv[i]   = rand_x();
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || want != '0 || pend.size() > 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 200, 1);
    repeat (2) step();
  endtask

  // Called just after a rising edge; holds rst low for one cycle.
  task automatic do_reset();
    want = '0;
    cont = '0;
    pend.delete();
    rst  = 1'b0;
    #1;
    chk("rst_rsp_vld", bus.rsp_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x_vld", bus.isqrt_x_vld, 0);
    chk("rst_err", err, 0);
    q.delete();
    ptr_m   = 0;
    last_g  = -1;
    err_exp = 1'b0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      xv[i]    = '0;
      waitc[i] = 0;
    end
    #1 rst = 1'b0;
    want = 4'b1010;
    #1;
    chk("rst_req_rdy", bus.req_rdy, 4'b0010);
    chk("rst_rsp_vld", bus.rsp_vld, 0);
    chk("rst_rsp_y", bus.rsp_y, 0);
    chk("rst_x_vld", bus.isqrt_x_vld, 0);
    chk("rst_x", bus.isqrt_x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    want = '0;
    @(posedge clk);
    #1 rst = 1'b1;

    // All four requesting continuously with (i+1)^2.
    for (int i = 0; i < N; i++) xv[i] = 32'((i + 1) * (i + 1));
    want = '1;
    cont = '1;
    repeat (12) step();
    cont = '0;
    drain();

    // Single request on requester 2.
    pend.push_back('{r: 2, x: 32'd144});
    drain();

    // Fairness: requesters 0 and 3 only.
    xv[0] = 32'd1000;
    xv[3] = 32'd99;
    want  = 4'b1001;
    cont  = 4'b1001;
    repeat (10) step();
    cont = '0;
    drain();

    // Boundary operands.
    pend.push_back('{r: 1, x: 32'd0});
    pend.push_back('{r: 1, x: 32'hFFFF_FFFF});
    pend.push_back('{r: 1, x: 32'd15});
    pend.push_back('{r: 1, x: 32'd16});
    drain();

    // Random traffic.
    rnd = 1'b1;
    repeat (400) step();
    rnd = 1'b0;
    drain();

    // Reset with three issues in flight.
    xv[0] = 32'd49;
    xv[1] = 32'd50;
    xv[2] = 32'd81;
    want  = 4'b0111;
    repeat (3) step();
    do_reset();
    repeat (L + 4) step();
    xv[3] = 32'd400;
    want  = '1;
    drain();

    // Spurious isqrt_y_vld pulse while idle.
    inj = 1'b1;
    step();
    inj     = 1'b0;
    err_exp = CHK_EN;
    repeat (5) step();
    do_reset();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
